control_sequencer: RTL

Parametrised T-state control sequencer for the 8-bit CPU, the next generation of the CPU control unit. It decodes the byte held in IR0 and drives the data-bus master/slave IDs, address-bus master ID, increment strobes and ALU enable each T-state. It extends the current control unit in three ways:
- variable-length multi-step instructions (LDAR, JMP, JZ);
- halt/resume handshake;
- optional memory wait states.

---
 rtl/control_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// T-state control sequencer: decodes IR0 into bus IDs, strobes and ALU enable each T-state.
// Optional memory wait states are enabled with the macro SEQ_WAIT_STATE_EN.
module control_sequencer #(
  parameter int T_STATES      = 8,
  parameter int ZERO_FLAG_BIT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          ir0,
  input  logic [3:0]          alu_status,
  input  logic                hlt,
  input  logic                resume,
  input  logic                mem_ready,
  output logic [T_STATES-1:0] t_onehot,
  output logic [2:0]          mid,
  output logic [2:0]          sid,
  output logic                mid_sid_en,
  output logic [1:0]          amid,
  output logic                pc_inr,
  output logic                ar_inr,
  output logic                alu_en,
  output logic [4:0]          alu_opcode,
  output logic                halted
);

  localparam int TW = $clog2(T_STATES);

  localparam logic [1:0] TYPE_MOV = 2'd0;
  localparam logic [1:0] TYPE_MVI = 2'd1;
  localparam logic [1:0] TYPE_ALU = 2'd2;

  localparam logic [4:0] SYS_HLT    = 5'd1;
  localparam logic [4:0] SYS_INC_AR = 5'd2;
  localparam logic [4:0] SYS_LDAR   = 5'd3;
  localparam logic [4:0] SYS_JMP    = 5'd4;
  localparam logic [4:0] SYS_JZ     = 5'd5;

  localparam logic [2:0] ID_MEM = 3'd1;

  typedef enum logic [1:0] {START, RUN, HALTED} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [1:0]    op_type;
  logic [4:0]    sys_op;
  logic          zero_flag;
  logic          jump_taken;
  logic          last_step;
  logic          halt_instr;
  logic          hold;
  logic          unused_inputs;

  assign op_type       = ir0[7:6];
  assign sys_op        = ir0[4:0];
  assign zero_flag     = alu_status[ZERO_FLAG_BIT];
  assign jump_taken    = (sys_op == SYS_JMP) || ((sys_op == SYS_JZ) && zero_flag);
  assign alu_opcode    = ir0[4:0];
  assign halted        = (state == HALTED);
  assign unused_inputs = ^{alu_status, mem_ready};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= START;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Step decode: everything idles outside RUN; later steps override the fetch-free defaults.
  always_comb begin
    t_onehot   = '0;
    mid        = 3'd7;
    sid        = 3'd7;
    mid_sid_en = 1'b0;
    amid       = 2'd0;
    pc_inr     = 1'b0;
    ar_inr     = 1'b0;
    alu_en     = 1'b0;
    last_step  = 1'b0;
    halt_instr = 1'b0;
    hold       = 1'b0;
    if (state == RUN) begin
      t_onehot = T_STATES'(1) << timer;
      if (timer == '0) begin
        mid        = ID_MEM;
        sid        = 3'd0;
        mid_sid_en = 1'b1;
        pc_inr     = 1'b1;
      end else if (timer == TW'(1)) begin
        last_step = 1'b1;
        case (op_type)
          TYPE_MOV: begin
            mid        = ir0[5:3];
            sid        = ir0[2:0];
            mid_sid_en = 1'b1;
            amid       = ((ir0[5:3] == ID_MEM) || (ir0[2:0] == ID_MEM)) ? 2'd1 : 2'd0;
          end
          TYPE_MVI: begin
            mid        = ID_MEM;
            sid        = ir0[2:0];
            mid_sid_en = 1'b1;
            pc_inr     = 1'b1;
          end
          TYPE_ALU: alu_en = 1'b1;
          default: begin
            if (sys_op == SYS_HLT) begin
              halt_instr = 1'b1;
            end else if (sys_op == SYS_INC_AR) begin
              ar_inr = 1'b1;
            end else if (sys_op == SYS_LDAR) begin
              mid        = ID_MEM;
              sid        = 3'd4;
              mid_sid_en = 1'b1;
              pc_inr     = 1'b1;
              last_step  = 1'b0;
            end else if (jump_taken) begin
              mid        = 3'd4;
              sid        = 3'd6;
              mid_sid_en = 1'b1;
              last_step  = 1'b0;
            end
          end
        endcase
      end else if ((timer == TW'(2)) && (op_type == 2'd3)) begin
        if (sys_op == SYS_LDAR) begin
          mid        = ID_MEM;
          sid        = 3'd5;
          mid_sid_en = 1'b1;
          pc_inr     = 1'b1;
          last_step  = 1'b1;
        end else if (jump_taken) begin
          mid        = 3'd5;
          sid        = 3'd7;
          mid_sid_en = 1'b1;
          last_step  = 1'b1;
        end
      end
    end
`ifdef SEQ_WAIT_STATE_EN
    // A memory step stalls until the memory answers; strobes fire only on the completing cycle.
    hold = mid_sid_en && ((mid == ID_MEM) || (sid == ID_MEM)) && !mem_ready;
    if (hold) begin
      pc_inr = 1'b0;
      ar_inr = 1'b0;
    end
`else
    hold = 1'b0;
`endif
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      START: begin
        state_next = RUN;
        timer_next = '0;
      end
      RUN: begin
        if (!hold) begin
          if (last_step || halt_instr) begin
            timer_next = '0;
            if (halt_instr || hlt) state_next = HALTED;
          end else if (timer == TW'(T_STATES - 1)) begin
            timer_next = '0;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
      end
      HALTED: begin
        if (resume && !hlt) begin
          state_next = RUN;
          timer_next = '0;
        end
      end
      default: begin
        state_next = START;
        timer_next = '0;
      end
    endcase
  end

endmodule
